// File: rtl/pulse_sched_pkg.sv
`default_nettype none
// ============================================================================
// pulse_sched_pkg : shared mode encoding and warm-up limit for the scheduler
// Revision: 1.0
// ============================================================================
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_PULSE = 2'b11
  } ev_mode_t;

  localparam logic [1:0] WARM_MAX = 2'd2;

endpackage
`default_nettype wire

// File: rtl/chan_event_detector.sv
`default_nettype none
// ============================================================================
// chan_event_detector : per-channel mode register, 2-sample history and
//                       warm-up counter driving a single-cycle detect strobe
// Revision: 1.0
// ============================================================================
module chan_event_detector
  import pulse_sched_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in,
  input  logic     cfg_we,
  input  ev_mode_t cfg_mode,
  output logic     det,
  output ev_mode_t mode
);

  logic [1:0] h_q, h_d;
  logic [1:0] warm_q, warm_d;
  ev_mode_t   mode_q, mode_d;

  always_comb begin
    h_d    = {in, h_q[1]};
    mode_d = mode_q;
    warm_d = warm_q;
    if (cfg_we) begin
      mode_d = cfg_mode;
      warm_d = 2'd0;
    end else if (warm_q < WARM_MAX) begin
      warm_d = warm_q + 2'd1;
    end
  end

  // h_q[1] is the previous sample, h_q[0] the one before it
  always_comb begin
    det = 1'b0;
    case (mode_q)
      MODE_RISE:  det = (warm_q >= 2'd1) & ~h_q[1] & in;
      MODE_FALL:  det = (warm_q >= 2'd1) & h_q[1] & ~in;
      MODE_PULSE: det = (warm_q == WARM_MAX) & ~h_q[0] & h_q[1] & ~in;
      default:    det = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= 2'b00;
      warm_q <= 2'd0;
      mode_q <= MODE_OFF;
    end else begin
      h_q    <= h_d;
      warm_q <= warm_d;
      mode_q <= mode_d;
    end
  end

  assign mode = mode_q;

endmodule
`default_nettype wire

// File: rtl/pulse_event_scheduler.sv
`default_nettype none
// ============================================================================
// pulse_event_scheduler : N_CH edge/pulse detectors feeding pending flags that
//                         a round-robin arbiter serializes onto one event port
// Revision: 1.0
// ============================================================================
module pulse_event_scheduler
  import pulse_sched_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in_lines,
  input  logic            cfg_we,
  input  logic [ID_W-1:0] cfg_ch,
  input  logic [1:0]      cfg_mode,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [ID_W-1:0] ev_ch,
  output logic [1:0]      ev_kind,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
);

  logic [N_CH-1:0] det_w;
  logic [N_CH-1:0] cfg_hit_w;
  ev_mode_t        mode_w [N_CH];

  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] grant_w;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] ev_ch_q, ev_ch_d;
  logic [1:0]      ev_kind_q, ev_kind_d;
  logic            ev_valid_q, ev_valid_d;
  logic            load_w;
  logic            found_w;
  logic [ID_W-1:0] gnt_idx_w;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cfg_hit_w[i] = cfg_we && (int'(cfg_ch) == i);
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    chan_event_detector u_det (
      .clk      (clk),
      .rst      (rst),
      .in       (in_lines[gi]),
      .cfg_we   (cfg_hit_w[gi]),
      .cfg_mode (ev_mode_t'(cfg_mode)),
      .det      (det_w[gi]),
      .mode     (mode_w[gi])
    );
  end

  // Search starts one past the last granted channel, wrapping at N_CH
  always_comb begin : p_arb
    logic [ID_W-1:0] cand;
    cand      = '0;
    found_w   = 1'b0;
    gnt_idx_w = '0;
    for (int off = 1; off <= N_CH; off++) begin
      cand = ID_W'((int'(ptr_q) + off) % N_CH);
      if (!found_w && pending_q[cand]) begin
        found_w   = 1'b1;
        gnt_idx_w = cand;
      end
    end
  end

  always_comb begin
    load_w  = ~ev_valid_q | ev_ready;
    grant_w = '0;
    if (load_w && found_w) begin
      grant_w[gnt_idx_w] = 1'b1;
    end

    // A detect on a granted channel re-arms it; a cfg write always wins
    pending_d = ((pending_q & ~grant_w) | det_w) & ~cfg_hit_w;
    ovf_d     = (ovf_clr ? '0 : ovf_q) | (det_w & pending_q & ~grant_w);

    ev_valid_d = ev_valid_q;
    ev_ch_d    = ev_ch_q;
    ev_kind_d  = ev_kind_q;
    ptr_d      = ptr_q;
    if (load_w) begin
      ev_valid_d = found_w;
      if (found_w) begin
        ev_ch_d   = gnt_idx_w;
        ev_kind_d = mode_w[gnt_idx_w];
        ptr_d     = gnt_idx_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      ovf_q      <= '0;
      ptr_q      <= ID_W'(N_CH - 1);
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
      ev_kind_q  <= 2'b00;
    end else begin
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      ptr_q      <= ptr_d;
      ev_valid_q <= ev_valid_d;
      ev_ch_q    <= ev_ch_d;
      ev_kind_q  <= ev_kind_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_ch    = ev_ch_q;
  assign ev_kind  = ev_kind_q;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_event_scheduler.sv
`default_nettype none
// ============================================================================
// tb_pulse_event_scheduler : directed cycle vectors plus a pulse hold sequence
// Revision: 1.0
// ============================================================================
module tb_pulse_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_lines;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_ch;
  logic [1:0] ev_kind;
  logic [3:0] ovf;
  logic       ovf_clr;

  pulse_event_scheduler #(.N_CH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_lines (in_lines),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ch    (ev_ch),
    .ev_kind  (ev_kind),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] in;
    logic       we;
    logic [1:0] ch;
    logic [1:0] mode;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [1:0] ech;
    logic [1:0] ek;
    logic [3:0] eovf;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(int r, int i, int w, int c, int m, int y, int l,
                              int e, int ec, int ek, int eo);
    vec_t v;
    v.rst  = r[0];
    v.in   = i[3:0];
    v.we   = w[0];
    v.ch   = c[1:0];
    v.mode = m[1:0];
    v.rdy  = y[0];
    v.clr  = l[0];
    v.ev   = e[0];
    v.ech  = ec[1:0];
    v.ek   = ek[1:0];
    v.eovf = eo[3:0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; in_lines = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_mode = '0; ev_ready = 1'b0; ovf_clr = 1'b0;

    //             rst in  we ch md rdy clr | ev ch kd ovf
    // ch0 RISE latency
    vq.push_back(mk(1, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 1, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h1, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h1, 0, 0, 0, 1, 0,  1, 0, 1, 0));
    vq.push_back(mk(0, 4'h1, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    // ch1 PULSE: 0,1,0 fires once, 0,1,1,0 does not
    vq.push_back(mk(0, 4'h0, 1, 1, 3, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h2, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  1, 1, 3, 0));
    vq.push_back(mk(0, 4'h2, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h2, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    // all four RISE together, twice: round-robin 0,1,2,3 each time
    vq.push_back(mk(1, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 1, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 1, 1, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 2, 1, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 3, 1, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 0, 0, 1, 0,  1, 0, 1, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  1, 1, 1, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  1, 2, 1, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  1, 3, 1, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 0, 0, 1, 0,  1, 0, 1, 0));
    vq.push_back(mk(0, 4'hF, 0, 0, 0, 1, 0,  1, 1, 1, 0));
    vq.push_back(mk(0, 4'hF, 0, 0, 0, 1, 0,  1, 2, 1, 0));
    vq.push_back(mk(0, 4'hF, 0, 0, 0, 1, 0,  1, 3, 1, 0));
    vq.push_back(mk(0, 4'hF, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    // ch2 FALL with back-pressure: hold, overflow, clear, set-beats-clear
    vq.push_back(mk(1, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h4, 1, 2, 2, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0,  1, 2, 2, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0,  1, 2, 2, 0));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0,  1, 2, 2, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0,  1, 2, 2, 4));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 0, 1,  1, 2, 2, 0));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 1, 0,  1, 2, 2, 0));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0,  1, 2, 2, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0,  1, 2, 2, 0));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0,  1, 2, 2, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1,  1, 2, 2, 4));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 1, 0,  1, 2, 2, 4));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 1, 0,  0, 0, 0, 4));
    vq.push_back(mk(0, 4'h4, 0, 0, 0, 1, 1,  0, 0, 0, 0));
    // cfg write drops pending[3]; warm-up masks the first sample on ch1
    vq.push_back(mk(1, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 1, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 3, 1, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h9, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h9, 0, 0, 0, 0, 0,  1, 0, 1, 0));
    vq.push_back(mk(0, 4'h9, 1, 3, 1, 0, 0,  1, 0, 1, 0));
    vq.push_back(mk(0, 4'h9, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h9, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h9, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h9, 1, 1, 1, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h9, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 0, 0, 1, 0,  1, 1, 1, 0));
    vq.push_back(mk(0, 4'hB, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    // reset mid-transfer with pending=1010 and ovf[1] set
    vq.push_back(mk(1, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 1, 1, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 3, 1, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h9, 0, 0, 0, 0, 0,  1, 0, 1, 0));
    vq.push_back(mk(0, 4'hB, 0, 0, 0, 0, 0,  1, 0, 1, 2));
    vq.push_back(mk(1, 4'hB, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 0, 0, 1, 0,  0, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0));

    for (int k = 0; k < vq.size(); k++) begin
      rst      = vq[k].rst;
      in_lines = vq[k].in;
      cfg_we   = vq[k].we;
      cfg_ch   = vq[k].ch;
      cfg_mode = vq[k].mode;
      ev_ready = vq[k].rdy;
      ovf_clr  = vq[k].clr;
      tick();
      check($sformatf("row%0d ev_valid", k), ev_valid, vq[k].ev);
      if (vq[k].ev || vq[k].rst) begin
        check($sformatf("row%0d ev_ch", k), ev_ch, vq[k].ech);
        check($sformatf("row%0d ev_kind", k), ev_kind, vq[k].ek);
      end
      check($sformatf("row%0d ovf", k), ovf, vq[k].eovf);
    end

    // PULSE on ch2 held under back-pressure, then drained
    rst = 1'b1; in_lines = '0; cfg_we = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    check("seq reset ev_valid", ev_valid, 0);
    check("seq reset ovf", ovf, 0);
    rst = 1'b0; cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'b11;
    tick();
    cfg_we = 1'b0;
    tick();
    tick();
    in_lines = 4'h4;
    tick();
    in_lines = 4'h0;
    tick();
    check("seq pending not yet visible", ev_valid, 0);
    n = 0;
    while (!ev_valid && n < 8) begin
      tick();
      n++;
    end
    check("seq pulse latency", n[7:0], 8'd1);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("seq hold%0d ev_valid", j), ev_valid, 1);
      check($sformatf("seq hold%0d ev_ch", j), ev_ch, 2);
      check($sformatf("seq hold%0d ev_kind", j), ev_kind, 3);
      tick();
    end
    ev_ready = 1'b1;
    tick();
    check("seq drained ev_valid", ev_valid, 0);
    check("seq drained ovf", ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_event_scheduler.md
Name: pulse_event_scheduler

Overview:
- Multi-channel event front end: each of N_CH input lines has its own edge/pulse detector with a run-time selected mode.
- Detected events are held as per-channel pending flags, then serialized onto one valid/ready event port by a round-robin arbiter.
- Sits between raw synchronous status lines and a single event consumer (interrupt/log logic).
- Reports lost events through sticky per-channel overflow flags.

Parameters:
- N_CH, 4, number of input channels (2..16).
- ID_W, $clog2(N_CH), derived localparam; channel index width, not overridable.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_lines  input  N_CH  raw synchronous input lines; bit i is channel i.
- cfg_we  input  1  mode write strobe.
- cfg_ch  input  ID_W  channel addressed by the mode write.
- cfg_mode  input  2  new mode: 00 OFF, 01 RISE (0->1), 10 FALL (1->0), 11 PULSE (010).
- ev_valid  output  1  event available.
- ev_ready  input  1  consumer accepts the event.
- ev_ch  output  ID_W  channel of the presented event.
- ev_kind  output  2  mode code of that channel when the event was granted.
- ovf  output  N_CH  sticky overflow flag per channel.
- ovf_clr  input  1  clears all ovf bits.

Behaviour:
- Reset (rst=1 at posedge) has the same effect at any time, including mid-transfer:
  - all modes return to OFF; pending=0; ev_valid=0; ev_ch=0; ev_kind=0; ovf=0.
  - RR pointer = N_CH-1, so channel 0 has first priority.
  - history registers = 0; warm counters = 0.
- History:
  - per channel, h[1:0] holds the previous two samples of in_lines[i].
  - update rule: h <= {in_lines[i], h[1]} every cycle.
- Warm-up:
  - a per-channel counter saturates at 2; it restarts from 0 after reset and after any cfg write to that channel.
  - RISE and FALL require count>=1; PULSE requires count==2. Until then, detection on that channel is forced to 0.
- Detection is combinational in the cycle where the pattern completes:
  - RISE: ~h[1] & in.
  - FALL: h[1] & ~in.
  - PULSE: ~h[0] & h[1] & ~in.
  - OFF: never.
- Pending flags:
  - at the posedge, det[i] sets pending[i].
  - if pending[i] is already set and not being granted at the same edge, the event is dropped and ovf[i] is set.
  - detection and grant on the same channel at the same edge: pending[i] stays set, no overflow.
- Output register:
  - loads when ev_valid=0, or when ev_valid & ev_ready (back-to-back grants allowed, 1 event/cycle).
  - at a load, it picks the first set pending bit searching from ptr+1 upward, with wrap-around.
  - it loads ev_ch and ev_kind, sets ev_valid, clears that pending bit, and sets ptr=ev_ch.
  - with no pending bits at a load opportunity, ev_valid goes to 0.
- Handshake:
  - while ev_valid=1 and ev_ready=0, ev_ch and ev_kind are held stable.
  - ev_valid never drops without a handshake, except on reset.
- Latency: pattern-completing sample in cycle k -> pending at edge k+1 -> ev_valid at edge k+2, given an empty or accepting output.
- cfg write:
  - takes effect at the posedge where cfg_we=1; the new mode governs detection from the next cycle on.
  - clears pending[cfg_ch] and restarts its warm counter.
  - an event already in the output register is not affected.
- ovf_clr clears all ovf bits; an overflow set in the same cycle wins for that bit.

Decomposition:
- Package pulse_sched_pkg holds:
  - typedef enum logic [1:0] ev_mode_t {MODE_OFF, MODE_RISE, MODE_FALL, MODE_PULSE}.
  - localparam WARM_MAX=2.
- Sub-module chan_event_detector, instantiated N_CH times via generate:
  - contains the history, warm counter and mode register.
  - ports: clk, rst, in, cfg_we, cfg_mode; output det.
- The top level owns the pending flags, ovf, the RR arbiter and the output register.

Test Plan:
- Reset, ch0=RISE, ready=1; in_lines[0] 0,0,1 at cycles 3..5 -> ev_valid=1, ev_ch=0, ev_kind=01 at cycle 7 for exactly one cycle.
- ch1=PULSE; in_lines[1] 0,1,0 -> one event ev_kind=11; then 0,1,1,0 -> no event.
- ch0..3=RISE, all rise in the same cycle, ready=1 -> ev_ch 0,1,2,3 on four consecutive cycles; repeat all rising -> grant order restarts after ptr=3, i.e. 0,1,2,3 again.
- ch2=FALL, ready=0, in_lines[2] falls twice -> one held event (ev_ch=2 stable) and ovf[2]=1; ovf_clr -> ovf=0; ready=1 -> exactly one event.
- Mode write to ch3 while pending[3]=1 -> pending cleared and no event emitted; input high at the first sample after a write to RISE -> no event during warm-up.
- rst asserted while ev_valid=1 and pending=4'b1010 -> next cycle ev_valid=0, ovf=0, modes OFF, and no events until reconfigured.
